ram_be_scrub: RTL
=================

Name: ram_be_scrub

Overview:
- Parametrised successor to the team's simple single-write, single-read register-array RAM.
- Adds per-byte write enables and a selectable registered or combinational read port with a valid flag.
- Adds a hardware scrub engine that fills every word with INIT_VALUE after reset and on request.
- Serves as page-table and metadata storage inside the MMU, where a known-clean memory after reset is required.

Parameters:
- ADDR_WIDTH, 6: address bits; DEPTH = 2^ADDR_WIDTH words.
- DATA_WIDTH, 64: word width; must be an integer multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH lanes.
- READ_REG, 1: 1 = one-cycle registered read; 0 = combinational read.
- INIT_VALUE, 0: BYTE_WIDTH-bit pattern replicated across all NB lanes during scrub.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset for the controller and output registers.
- clear_req  input  1  single-cycle request to start a scrub.
- busy  output  1  high while scrubbing.
- init_done  output  1  sticky; set when the first scrub after reset completes.
- write_en  input  1  write strobe.
- write_addr  input  ADDR_WIDTH  write address.
- write_be  input  NB  per-lane write enable; bit i covers data bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- write_data  input  DATA_WIDTH  write data.
- read_en  input  1  read strobe.
- read_addr  input  ADDR_WIDTH  read address.
- read_data  output  DATA_WIDTH  read data.
- read_valid  output  1  read_data is valid for an accepted read.

Behaviour:
- Reset:
  - Asynchronous; clears the controller and output registers only. The memory array has no reset.
  - Reset values: state=CLEAR, scrub counter=0, busy=1, init_done=0, read_valid=0, read_data=0 (READ_REG=1).
- FSM, two states:
  - CLEAR: each cycle write {NB{INIT_VALUE}} to address = counter, then counter+1. When counter==DEPTH-1, that write completes and the next state is IDLE. A scrub therefore takes exactly DEPTH cycles; busy is high for all of them and drops on the cycle IDLE is entered. init_done is set on that same edge and held until reset. Counter wraps to 0.
  - IDLE: clear_req=1 moves to CLEAR with counter=0 and busy=1 from the next cycle. User accesses on the request cycle itself are still serviced.
- While busy:
  - clear_req is ignored; it does not restart the scrub.
  - write_en is ignored and no user write reaches the array.
  - read_en is ignored and read_valid stays 0.
  - Reset asserted mid-scrub restarts the scrub from address 0.
- Writes (IDLE only):
  - On the rising edge with write_en=1, lanes with write_be[i]=1 are updated and all other lanes keep their previous value.
  - write_be=0 leaves the array unchanged.
- Reads, READ_REG=1:
  - read_en=1 in IDLE: on the next cycle read_data = mem[read_addr] and read_valid=1.
  - When not reading, read_valid=0 and read_data holds its last value.
  - Same-cycle write to the same address is write-first per lane: enabled lanes return write_data, disabled lanes return the old contents.
- Reads, READ_REG=0:
  - read_data = mem[read_addr] combinationally; read_valid = read_en & ~busy.
  - Same-cycle write to the same address returns the old word; the new value is visible after the edge.
- Simultaneous clear_req and write_en in IDLE: the write completes, then the scrub overwrites the whole array.
- Timing: one array write port shared by scrub and user writes through a mux selected by state. Reads never stall.

Test Plan:
1. Reset, then hold rst_n=1 with defaults (DEPTH=64) -> busy=1 for exactly 64 cycles, init_done rises on the same edge busy falls, all 64 words read 0.
2. IDLE, write addr 5 data 0x1122334455667788 be=0xFF, then write addr 5 data 0xAAAAAAAAAAAAAAAA be=0x0F -> read addr 5 returns 0x11223344AAAAAAAA; READ_REG=1 gives read_valid one cycle after read_en.
3. READ_REG=1, same-cycle write addr 9 data 0xFFFF0000FFFF0000 be=0xF0 (old word 0) with read addr 9 -> read_data = 0xFFFF000000000000 next cycle; READ_REG=0 build returns 0 in the same cycle.
4. After init, write addr 3 = 0xDEAD; pulse clear_req with a concurrent write to addr 3 -> busy for 64 cycles, read_en during busy gives read_valid=0, a write to addr 7 during busy is dropped, addr 3 and addr 7 read 0 afterwards.
5. Assert rst_n=0 at scrub counter 20 with INIT_VALUE=0xA5, pre-filled array of 0x00 -> after release busy lasts a full 64 cycles and every word reads 0xA5A5A5A5A5A5A5A5.
6. clear_req pulsed repeatedly during busy -> scrub length stays 64 cycles, no restart, init_done remains 1.

Source files
------------

// File: rtl/ram_be_scrub.sv
// ram_be_scrub: byte-enable register-array RAM with hardware scrub.
// Fills every word with INIT_VALUE after reset and on clear_req.
module ram_be_scrub #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 64,
   parameter int BYTE_WIDTH = 8,
   parameter bit READ_REG = 1'b1,
   parameter logic [BYTE_WIDTH-1:0] INIT_VALUE = '0,
   localparam int NB = DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_req,
   output logic                  busy,
   output logic                  init_done,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [NB-1:0]         write_be,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  read_en,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  read_valid
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [DATA_WIDTH-1:0] FILL = {NB{INIT_VALUE}};

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_IDLE  = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] w_cnt_nxt;
   logic                  r_init_done;
   logic                  w_init_done_nxt;
   logic                  w_busy;

   logic                  w_mem_we;
   logic [ADDR_WIDTH-1:0] w_mem_addr;
   logic [NB-1:0]         w_mem_be;
   logic [DATA_WIDTH-1:0] w_mem_wdata;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] w_rd_word;
   logic                  w_rd_ok;

   assign w_busy    = (r_state == S_CLEAR);
   assign busy      = w_busy;
   assign init_done = r_init_done;

   // Controller state, scrub counter and sticky init flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_CLEAR;
         r_cnt       <= '0;
         r_init_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_init_done <= w_init_done_nxt;
      end
   end

   // Next state: walk the counter through every word, then idle.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_init_done_nxt = r_init_done;
      unique case (r_state)
         S_CLEAR: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == LAST) begin
               w_state_nxt     = S_IDLE;
               w_init_done_nxt = 1'b1;
            end
         end
         S_IDLE: begin
            if (clear_req) begin
               w_state_nxt = S_CLEAR;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = S_CLEAR;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Single array write port: scrub owns it while busy.
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_addr  = write_addr;
      w_mem_be    = write_be;
      w_mem_wdata = write_data;
      if (w_busy) begin
         w_mem_we    = 1'b1;
         w_mem_addr  = r_cnt;
         w_mem_be    = '1;
         w_mem_wdata = FILL;
      end else begin
         w_mem_we    = write_en;
      end
   end

   // Storage array, no reset; lanes update per byte enable.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int i = 0; i < NB; i++) begin
            if (w_mem_be[i]) begin
               r_mem[w_mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH]
                  <= w_mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   assign w_rd_word = r_mem[read_addr];
   assign w_rd_ok   = read_en & ~w_busy;

   if (READ_REG) begin : g_rreg
      logic [DATA_WIDTH-1:0] w_fwd;
      logic [DATA_WIDTH-1:0] r_rd_data;
      logic                  r_rd_valid;
      logic                  w_hit;

      assign w_hit = write_en & ~w_busy & (write_addr == read_addr);

      // Write-first merge: enabled lanes of a colliding write win.
      always_comb begin
         w_fwd = w_rd_word;
         if (w_hit) begin
            for (int i = 0; i < NB; i++) begin
               if (write_be[i]) begin
                  w_fwd[i*BYTE_WIDTH +: BYTE_WIDTH] =
                     write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
               end
            end
         end
      end

      // Registered read port; data holds when no read is accepted.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
         end else begin
            r_rd_valid <= w_rd_ok;
            if (w_rd_ok) begin
               r_rd_data <= w_fwd;
            end
         end
      end

      assign read_data  = r_rd_data;
      assign read_valid = r_rd_valid;
   end else begin : g_rcomb
      assign read_data  = w_rd_word;
      assign read_valid = w_rd_ok;
   end

endmodule
